// File: rtl/song_reader_if.sv
// Control and ROM bus between the song reader and its environment (player, song ROM).
// master = environment side, slave = song_reader side.
interface song_reader_if #(
  parameter int NOTES_PER_SONG = 32,
  parameter int SONG_BITS      = 2
);
  localparam int IDX = $clog2(NOTES_PER_SONG);

  logic                     play;
  logic [SONG_BITS-1:0]     song;
  logic                     note_done;
  logic [SONG_BITS+IDX-1:0] rom_addr;
  logic [11:0]              rom_data;
  logic [5:0]               note;
  logic [5:0]               duration;
  logic                     new_note;
  logic                     song_done;

  modport master (
    output play, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );

  modport slave (
    input  play, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Walks a song ROM one entry at a time, handing each (note, duration) to the note
// player and waiting for it to finish; a zero duration or the last slot ends the song.
module song_reader #(
  parameter int NOTES_PER_SONG = 32,  // must be a power of two and match the bus instance
  parameter int SONG_BITS      = 2
) (
  input  logic         clk,
  input  logic         reset,
  song_reader_if.slave bus
);
  localparam int IDX = $clog2(NOTES_PER_SONG);
  localparam logic [IDX-1:0] LAST_INDEX = IDX'(NOTES_PER_SONG - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, PLAYING, END} state_t;

  state_t                   state;
  logic [SONG_BITS-1:0]     song_q;
  logic [IDX-1:0]           note_index;
  logic [SONG_BITS+IDX-1:0] rom_addr_q;
  logic [5:0]               note_q;
  logic [5:0]               duration_q;
  logic                     new_note_q;
  logic                     song_done_q;

  logic [5:0]     rom_note;
  logic [5:0]     rom_duration;
  logic [IDX-1:0] next_index;
  logic           start_song;

  assign rom_note     = bus.rom_data[11:6];
  assign rom_duration = bus.rom_data[5:0];
  assign next_index   = note_index + IDX'(1);

  // Play from IDLE, or a song switch while active, both restart at entry 0 of bus.song.
  assign start_song = bus.play &&
                      ((state == IDLE) || ((state != END) && (bus.song != song_q)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      song_q      <= '0;
      note_index  <= '0;
      rom_addr_q  <= '0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make both strobes one-cycle pulses unless a branch re-arms them.
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;

      if (start_song) begin
        song_q     <= bus.song;
        note_index <= '0;
        rom_addr_q <= {bus.song, {IDX{1'b0}}};
        state      <= FETCH;
      end else begin
        case (state)
          IDLE: ;

          FETCH:
            if (bus.play) state <= WAIT;

          // ROM output is only trusted one full cycle after the address; a freeze
          // here sends us back through FETCH so the word is re-read on resume.
          WAIT:
            if (!bus.play) begin
              state <= FETCH;
            end else if (rom_duration == 6'd0) begin
              song_done_q <= 1'b1;
              state       <= END;
            end else begin
              note_q     <= rom_note;
              duration_q <= rom_duration;
              new_note_q <= 1'b1;
              state      <= ISSUE;
            end

          // A freeze here drops the strobe; on resume it is re-issued once before PLAYING.
          ISSUE:
            if (bus.play) begin
              if (new_note_q) state <= PLAYING;
              else            new_note_q <= 1'b1;
            end

          // The note player may finish while we are frozen, so note_done is not gated by play.
          PLAYING:
            if (bus.note_done) begin
              if (note_index == LAST_INDEX) begin
                song_done_q <= 1'b1;
                state       <= END;
              end else begin
                note_index <= next_index;
                rom_addr_q <= {song_q, next_index};
                state      <= FETCH;
              end
            end

          END: begin
            note_index <= '0;
            state      <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.note      = note_q;
  assign bus.duration  = duration_q;
  assign bus.new_note  = new_note_q;
  assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: synchronous ROM model plus a song-level
// reference (expected note list derived from ROM contents and end-of-song rules).
`timescale 1ns/1ps
module tb_song_reader;
  localparam int N  = 32;
  localparam int SB = 2;
  localparam int IW = 5;
  localparam int AW = SB + IW;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  song_reader_if #(.NOTES_PER_SONG(N), .SONG_BITS(SB)) bus ();

  song_reader #(.NOTES_PER_SONG(N), .SONG_BITS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [0:(1<<AW)-1];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0]   obs_q[$];
  logic [AW-1:0] obs_addr_q[$];

  // Number of notes a song yields: entries up to the first zero duration, at most N.
  function automatic int expected_len(input logic [SB-1:0] s);
    for (int i = 0; i < N; i++)
      if (rom[{s, IW'(i)}][5:0] == 6'd0) return i;
    return N;
  endfunction

  function automatic logic [11:0] entry(input logic [SB-1:0] s, input int i);
    return rom[{s, IW'(i)}];
  endfunction

  task automatic do_reset();
    bus.play      = 1'b0;
    bus.note_done = 1'b0;
    bus.song      = '0;
    reset         = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_new_note(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus.new_note) seen = 1'b1;
    end
  endtask

  // Plays song s to completion, acknowledging each note after a random delay.
  task automatic play_song(input logic [SB-1:0] s, input int budget,
                           output int n_new, output int n_done,
                           output int n_overlap, output bit timeout);
    int cyc      = 0;
    bit pending  = 1'b0;
    int wait_cnt = 0;
    n_new = 0; n_done = 0; n_overlap = 0; timeout = 1'b0;
    obs_q.delete();
    obs_addr_q.delete();
    bus.song      = s;
    bus.play      = 1'b1;
    bus.note_done = 1'b0;
    while (n_done == 0 && !timeout) begin
      @(negedge clk);
      cyc++;
      bus.note_done = 1'b0;
      if (bus.new_note && bus.song_done) n_overlap++;
      if (bus.song_done) n_done++;
      if (bus.new_note) begin
        obs_q.push_back({bus.note, bus.duration});
        obs_addr_q.push_back(bus.rom_addr);
        n_new++;
        pending  = 1'b1;
        wait_cnt = int'($urandom_range(0, 3));
      end else if (pending) begin
        if (wait_cnt == 0) begin
          bus.note_done = 1'b1;
          pending       = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (cyc >= budget) timeout = 1'b1;
    end
    bus.play      = 1'b0;
    bus.note_done = 1'b0;
  endtask

  task automatic check_song(input string name, input logic [SB-1:0] s, input int budget);
    int n_new, n_done, n_ov, exp_len, post;
    bit to;
    exp_len = expected_len(s);
    play_song(s, budget, n_new, n_done, n_ov, to);
    n_checks++;
    if (to) $display("FAIL %s_timeout: song_done not seen within %0d cycles", name, budget);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL %s_done: song_done count=%0d expected 1", name, n_done);
    else n_pass++;
    n_checks++;
    if (n_ov != 0) $display("FAIL %s_overlap: new_note&song_done cycles=%0d expected 0", name, n_ov);
    else n_pass++;
    n_checks++;
    if (n_new != exp_len) $display("FAIL %s_count: new_note pulses=%0d expected %0d", name, n_new, exp_len);
    else n_pass++;
    for (int i = 0; i < n_new && i < exp_len; i++) begin
      n_checks++;
      if (obs_q[i] !== entry(s, i))
        $display("FAIL %s_entry%0d: note/dur=%h expected %h", name, i, obs_q[i], entry(s, i));
      else n_pass++;
      n_checks++;
      if (obs_addr_q[i] !== {s, IW'(i)})
        $display("FAIL %s_addr%0d: rom_addr=%h expected %h", name, i, obs_addr_q[i], {s, IW'(i)});
      else n_pass++;
    end
    post = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.new_note || bus.song_done) post++;
    end
    n_checks++;
    if (post != 0) $display("FAIL %s_idle_after: strobe cycles=%0d expected 0", name, post);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.play      = 1'b1;
    bus.song      = 2'd3;
    bus.note_done = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.rom_addr !== '0) $display("FAIL reset_rom_addr: got %h expected 0", bus.rom_addr);
    else n_pass++;
    n_checks++;
    if (bus.note !== 6'd0) $display("FAIL reset_note: got %h expected 0", bus.note);
    else n_pass++;
    n_checks++;
    if (bus.duration !== 6'd0) $display("FAIL reset_duration: got %h expected 0", bus.duration);
    else n_pass++;
    n_checks++;
    if (bus.new_note !== 1'b0) $display("FAIL reset_new_note: got %b expected 0", bus.new_note);
    else n_pass++;
    n_checks++;
    if (bus.song_done !== 1'b0) $display("FAIL reset_song_done: got %b expected 0", bus.song_done);
    else n_pass++;
    do_reset();
  endtask

  // Fixed song 1: exact cycle timing of the first two notes and the end marker.
  task automatic test_first_song();
    int n_new = 0, n_done = 0, done_at = 0;
    bus.song = 2'd1;
    bus.play = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rom_addr !== 7'h20) $display("FAIL first_addr: rom_addr=%h expected 20", bus.rom_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.new_note !== 1'b0) $display("FAIL first_early: new_note=%b expected 0", bus.new_note);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.new_note, bus.note, bus.duration} !== {1'b1, 6'd1, 6'd5})
      $display("FAIL first_issue: new/note/dur=%b/%0d/%0d expected 1/1/5",
               bus.new_note, bus.note, bus.duration);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.new_note !== 1'b0) $display("FAIL first_pulse_width: new_note=%b expected 0", bus.new_note);
    else n_pass++;
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 7'h21) $display("FAIL second_addr: rom_addr=%h expected 21", bus.rom_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.new_note, bus.note, bus.duration} !== {1'b1, 6'd10, 6'd3})
      $display("FAIL second_issue: new/note/dur=%b/%0d/%0d expected 1/10/3",
               bus.new_note, bus.note, bus.duration);
    else n_pass++;
    @(negedge clk);
    bus.note_done = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.note_done = 1'b0;
      if (bus.new_note) n_new++;
      if (bus.song_done) begin
        n_done++;
        done_at  = c;
        bus.play = 1'b0;
      end
    end
    n_checks++;
    if (n_new != 0) $display("FAIL end_no_third: new_note pulses=%0d expected 0", n_new);
    else n_pass++;
    n_checks++;
    if (n_done != 1 || done_at != 3)
      $display("FAIL end_song_done: count=%0d at=%0d expected 1 at 3", n_done, done_at);
    else n_pass++;
  endtask

  task automatic test_random_songs();
    for (int it = 0; it < 4; it++) begin
      int len;
      for (int i = 0; i < N; i++)
        rom[{2'd0, IW'(i)}] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
      len = int'($urandom_range(1, N - 1));
      rom[{2'd0, IW'(len)}][5:0] = 6'd0;
      check_song("rand", 2'd0, 1000);
    end
  endtask

  task automatic test_freeze_issue();
    bit seen;
    int low_cnt = 0, hi_cnt = 0;
    logic [11:0] got = '0;
    bus.song = 2'd2;
    bus.play = 1'b1;
    wait_new_note(10, seen);
    n_checks++;
    if (!seen || {bus.note, bus.duration} !== entry(2'd2, 0))
      $display("FAIL freeze_issue_first: seen=%b note/dur=%h expected 1/%h",
               seen, {bus.note, bus.duration}, entry(2'd2, 0));
    else n_pass++;
    bus.play = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.new_note) low_cnt++;
    end
    n_checks++;
    if (low_cnt != 0) $display("FAIL freeze_issue_low: new_note pulses=%0d expected 0", low_cnt);
    else n_pass++;
    bus.play = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.new_note) begin
        hi_cnt++;
        got = {bus.note, bus.duration};
      end
    end
    n_checks++;
    if (hi_cnt != 1 || got !== entry(2'd2, 0))
      $display("FAIL freeze_issue_resume: pulses=%0d note/dur=%h expected 1/%h",
               hi_cnt, got, entry(2'd2, 0));
    else n_pass++;
    do_reset();
  endtask

  task automatic test_freeze_wait();
    int low_cnt = 0, hi_cnt = 0;
    logic [11:0] got = '0;
    bus.song = 2'd2;
    bus.play = 1'b1;
    repeat (2) @(negedge clk);
    bus.play = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.new_note) low_cnt++;
    end
    n_checks++;
    if (low_cnt != 0) $display("FAIL freeze_wait_low: new_note pulses=%0d expected 0", low_cnt);
    else n_pass++;
    bus.play = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.new_note) begin
        hi_cnt++;
        got = {bus.note, bus.duration};
      end
    end
    n_checks++;
    if (hi_cnt != 1 || got !== entry(2'd2, 0))
      $display("FAIL freeze_wait_resume: pulses=%0d note/dur=%h expected 1/%h",
               hi_cnt, got, entry(2'd2, 0));
    else n_pass++;
    do_reset();
  endtask

  task automatic test_note_done_play_low();
    int cnt = 0;
    bus.song = 2'd2;
    bus.play = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.note_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rom_addr !== 7'h40) $display("FAIL done_ignored: rom_addr=%h expected 40", bus.rom_addr);
    else n_pass++;
    bus.play      = 1'b0;
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    n_checks++;
    if (bus.rom_addr !== 7'h41) $display("FAIL done_play_low: rom_addr=%h expected 41", bus.rom_addr);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (bus.new_note) cnt++;
    end
    n_checks++;
    if (cnt != 0) $display("FAIL done_frozen: new_note pulses=%0d expected 0", cnt);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_song_change();
    bit seen;
    int n_new = 0, n_done = 0;
    logic [11:0] got = '0;
    bus.song = 2'd1;
    bus.play = 1'b1;
    wait_new_note(10, seen);
    @(negedge clk);
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
    wait_new_note(10, seen);
    n_checks++;
    if (!seen || bus.note !== 6'd10) $display("FAIL change_setup: seen=%b note=%0d expected 1/10", seen, bus.note);
    else n_pass++;
    @(negedge clk);
    bus.song = 2'd2;
    @(negedge clk);
    n_checks++;
    if (bus.rom_addr !== 7'h40) $display("FAIL change_addr: rom_addr=%h expected 40", bus.rom_addr);
    else n_pass++;
    repeat (4) begin
      @(negedge clk);
      if (bus.song_done) n_done++;
      if (bus.new_note) begin
        n_new++;
        got = {bus.note, bus.duration};
      end
    end
    n_checks++;
    if (n_new != 1 || n_done != 0 || got !== entry(2'd2, 0))
      $display("FAIL change_issue: pulses=%0d done=%0d note/dur=%h expected 1/0/%h",
               n_new, n_done, got, entry(2'd2, 0));
    else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.song = 2'd2;
    bus.play = 1'b1;
    wait_new_note(10, seen);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.rom_addr, bus.note, bus.duration, bus.new_note, bus.song_done} !== '0)
      $display("FAIL reset_async: addr/note/dur/new/done=%h/%h/%h/%b/%b expected all 0",
               bus.rom_addr, bus.note, bus.duration, bus.new_note, bus.song_done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rom_addr !== 7'h40) $display("FAIL reset_restart_addr: rom_addr=%h expected 40", bus.rom_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (!bus.new_note || {bus.note, bus.duration} !== entry(2'd2, 0))
      $display("FAIL reset_restart_issue: new/note-dur=%b/%h expected 1/%h",
               bus.new_note, {bus.note, bus.duration}, entry(2'd2, 0));
    else n_pass++;
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      rom[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
    rom[7'h20] = {6'd1,  6'd5};
    rom[7'h21] = {6'd10, 6'd3};
    rom[7'h22] = {6'd63, 6'd0};
    bus.play      = 1'b0;
    bus.song      = '0;
    bus.note_done = 1'b0;

    test_reset();
    test_first_song();
    check_song("long", 2'd3, 2000);
    test_random_songs();
    test_freeze_issue();
    test_freeze_wait();
    test_note_done_play_low();
    test_song_change();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter: NOTES_PER_SONG, default 32, entries per song; SHALL be a power of two; index width IDX = log2(NOTES_PER_SONG).
REQ-002 Parameter: SONG_BITS, default 2, song-select width.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; low SHALL force reset state immediately, independent of clk.
REQ-005 Port: play  input  1  level enable; high = advance through song, low = freeze.
REQ-006 Port: song  input  SONG_BITS  song select.
REQ-007 Port: note_done  input  1  one-cycle pulse from note_player (done_with_note).
REQ-008 Port: rom_addr  output  SONG_BITS+IDX  registered song ROM address {song_q, note_index}.
REQ-009 Port: rom_data  input  12  ROM word {note[11:6], duration[5:0]}, valid one cycle after rom_addr is captured.
REQ-010 Port: note  output  6  registered note to load (feeds note_to_load).
REQ-011 Port: duration  output  6  registered duration in beats (feeds duration_to_load).
REQ-012 Port: new_note  output  1  one-cycle load strobe (feeds load_new_note).
REQ-013 Port: song_done  output  1  one-cycle pulse at end of song.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, WAIT, ISSUE, PLAYING, END.
REQ-015 IDLE: play=1 -> FETCH, latching song into song_q and clearing note_index to 0; else stay.
REQ-016 FETCH: rom_addr = {song_q, note_index}; -> WAIT next cycle.
REQ-017 WAIT: rom_data sampled; duration field 0 -> END (end-of-song marker, note/duration unchanged); else note/duration registers load from rom_data -> ISSUE.
REQ-018 ISSUE: new_note=1 for exactly this cycle, note/duration stable; -> PLAYING.
REQ-019 PLAYING: note_done=1 -> if note_index = NOTES_PER_SONG-1 then END, else note_index+1 and FETCH.
REQ-020 END: song_done=1 for exactly this cycle; note_index cleared; -> IDLE.
REQ-021 Latency: play rising in IDLE at edge k -> new_note high in cycle k+3.
REQ-022 play=0 in FETCH, WAIT, ISSUE or PLAYING SHALL hold state and all registers; new_note SHALL NOT be asserted while play=0; ISSUE resumes and pulses once when play returns.
REQ-023 WAIT has no play gating hazard: rom_data re-read because FETCH->WAIT repeats after a freeze in WAIT (freeze in WAIT returns to FETCH on resume).
REQ-024 note_done outside PLAYING SHALL be ignored; note_done and play=0 in PLAYING SHALL still be accepted (note already finished).
REQ-025 song != song_q in any non-IDLE, non-END state (play=1): song_q <= song, note_index <= 0, -> FETCH next cycle; song_done SHALL NOT pulse.
REQ-026 note_index SHALL never wrap silently; final entry always routes through END.
REQ-027 new_note and song_done SHALL never be high in the same cycle.

Reset
REQ-028 reset low: state IDLE, note_index 0, song_q 0, rom_addr 0, note 0, duration 0, new_note 0, song_done 0.
REQ-029 reset asserted mid-note SHALL abort without pulsing new_note or song_done; after release, operation restarts from IDLE.

Verification
REQ-030 ROM model song 1 = (note 1,dur 5),(note 10,dur 3),(x,0); play=1 at edge k -> rom_addr 0x20 at k+1, new_note at k+3 with note=1,duration=5.
REQ-031 Pulse note_done in PLAYING -> rom_addr 0x21, new_note 3 cycles later with note=10,duration=3; next note_done -> duration-0 entry -> song_done one cycle, IDLE, no third new_note.
REQ-032 Song of 32 nonzero entries, pulse note_done 32 times -> exactly 32 new_note pulses, song_done after 32nd, rom_addr never reaches next song's region.
REQ-033 Drop play during ISSUE for 10 cycles -> no new_note while low, exactly one new_note after resume, same note/duration.
REQ-034 Change song from 1 to 2 while PLAYING at index 1 -> rom_addr 0x40 next cycle, new_note with song 2 entry 0, no song_done.
REQ-035 Assert reset asynchronously between edges in PLAYING -> all outputs 0 immediately; play=1 after release restarts at index 0.
